mig_burst_dma: RTL and testbench

MIG_BURST_DMA -- requirements
Module: mig_burst_dma

---
 rtl/mig_burst_dma.sv | 157 +++++++++++++++
 tb/tb_mig_burst_dma.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mig_burst_dma.sv
// Burst DMA engine between a simple command/stream interface and a MIG AXI-like port.
// Splits each command into bursts limited by MAX_BURST and 4 KB address boundaries.
module mig_burst_dma #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    // command
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_beats,
    // status
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    // MIG side
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic                    arvalid,
    output logic                    awvalid,
    output logic [7:0]              arwlen,
    output logic                    wvalid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    bready,
    input  logic                    arready,
    input  logic                    awready,
    input  logic                    wready,
    input  logic                    bvalid,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    data_valid,
    input  logic                    rw_last,
    // streams
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StAddr, StRdata, StWdata, StWresp, StDone} state_e;

    state_e                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_dir;
    logic                  r_err;
    logic [8:0]            r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic [12:0]           w_to_boundary;
    logic [8:0]            w_cap;
    logic [8:0]            w_burst;
    logic [8:0]            w_beat_next;
    logic                  w_accept;
    logic                  w_wbeat;
    logic                  w_burst_done;
    logic [LEN_WIDTH-1:0]  w_rem_after;

    // Burst size is a pure function of cur_addr/remaining, which stay put during a burst.
    always_comb begin
        w_to_boundary = (13'd4096 - {1'b0, r_cur_addr[11:0]}) / 13'(BYTES);
        w_cap = (13'(MAX_BURST) < w_to_boundary) ? 9'(MAX_BURST) : 9'(w_to_boundary);
        w_burst = (32'(r_remaining) < 32'(w_cap)) ? 9'(r_remaining) : w_cap;
    end

    assign w_beat_next  = r_beat_cnt + 9'd1;
    assign w_accept     = (r_state == StIdle) && cmd_valid;
    assign w_wbeat      = (r_state == StWdata) && wr_valid && wready;
    assign w_burst_done = ((r_state == StRdata) && data_valid && rw_last) ||
                          ((r_state == StWresp) && bvalid);
    assign w_rem_after  = r_remaining - LEN_WIDTH'(w_burst);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (cmd_valid) w_state_next = (cmd_beats == '0) ? StDone : StAddr;
            end
            StAddr: begin
                if (r_dir && awready)       w_state_next = StWdata;
                else if (!r_dir && arready) w_state_next = StRdata;
            end
            StRdata: begin
                if (w_burst_done) w_state_next = (w_rem_after == '0) ? StDone : StAddr;
            end
            StWdata: begin
                if (w_wbeat && wlast) w_state_next = StWresp;
            end
            StWresp: begin
                if (w_burst_done) w_state_next = (w_rem_after == '0) ? StDone : StAddr;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == StIdle);
        busy      = (r_state != StIdle);
        done      = (r_state == StDone);
        err       = r_err;
        addr      = (r_state == StAddr) ? r_cur_addr : '0;
        arvalid   = (r_state == StAddr) && !r_dir;
        awvalid   = (r_state == StAddr) && r_dir;
        arwlen    = (w_burst == 9'd0) ? 8'd0 : 8'(w_burst - 9'd1);
        wvalid    = (r_state == StWdata) && wr_valid;
        wr_ready  = (r_state == StWdata) && wready;
        wdata     = (r_state == StWdata) ? wr_data : '0;
        wstrb     = (r_state == StWdata) ? '1 : '0;
        wlast     = (r_state == StWdata) && (w_beat_next == w_burst);
        bready    = (r_state == StWresp);
        rd_data   = r_rd_data;
        rd_valid  = r_rd_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_dir       <= 1'b0;
            r_err       <= 1'b0;
            r_beat_cnt  <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rd_valid <= (r_state == StRdata) && data_valid;
            if ((r_state == StRdata) && data_valid) r_rd_data <= data;
            if (w_accept) begin
                r_cur_addr  <= cmd_addr;
                r_remaining <= cmd_beats;
                r_dir       <= cmd_dir;
                r_err       <= 1'b0;
                r_beat_cnt  <= '0;
            end
            if ((r_state == StRdata) && data_valid) begin
                r_beat_cnt <= rw_last ? 9'd0 : w_beat_next;
                // A short or long read burst still completes; only the flag records it.
                if (rw_last && (w_beat_next != w_burst)) r_err <= 1'b1;
            end
            if (w_wbeat) r_beat_cnt <= wlast ? 9'd0 : w_beat_next;
            if (w_burst_done) begin
                r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(w_burst) * ADDR_WIDTH'(BYTES);
                r_remaining <= w_rem_after;
            end
        end
    end
endmodule

// File: tb/tb_mig_burst_dma.sv
// Directed bench for mig_burst_dma: a small reactive MIG model plus hand-computed expectations.
module tb_mig_burst_dma;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 512;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_beats = '0;
    logic          busy, done, err;
    logic [AW-1:0] addr;
    logic          arvalid, awvalid, wvalid, wlast, bready;
    logic [7:0]    arwlen;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          arready = 1'b1, awready = 1'b1, wready = 1'b0, bvalid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          data_valid = 1'b0, rw_last = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0, wr_ready;

    mig_burst_dma #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(16), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .busy(busy), .done(done), .err(err),
        .addr(addr), .arvalid(arvalid), .awvalid(awvalid), .arwlen(arwlen),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .bready(bready),
        .arready(arready), .awready(awready), .wready(wready), .bvalid(bvalid),
        .data(data), .data_valid(data_valid), .rw_last(rw_last),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Records of one command run
    logic [31:0] q_addr[$];
    logic [7:0]  q_len[$];
    int          wlast_at[$];
    int n_ar, n_aw, rd_cnt, done_cnt, done_cyc, bresp, aw_overlap, wbeat;

    // short_last: if >0, rw_last comes on that beat of every read burst.
    // abort_wbeat: if >0, rst is raised right after that many write beats.
    task automatic run_cmd(input logic dir, input logic [31:0] a, input logic [15:0] beats,
                           input int short_last, input int abort_wbeat, input bit wtoggle);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_d;
        bit   rd_active = 0, b_pend = 0, fin = 0;
        int   rd_idx = 0, rd_len = 0, b_wait = 0, cyc = 0;
        logic [31:0] seq = 32'h100, wseq = 32'h9000;
        q_addr.delete(); q_len.delete(); wlast_at.delete();
        n_ar = 0; n_aw = 0; rd_cnt = 0; done_cnt = 0; done_cyc = -1;
        bresp = 0; aw_overlap = 0; wbeat = 0;
        cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = a; cmd_beats = beats;
        #1;
        check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!fin && cyc < 2000) begin
            data_valid = rd_active;
            rw_last    = rd_active &&
                         (rd_idx + 1 == ((short_last > 0) ? short_last : rd_len));
            data       = {16{seq}};
            wready     = wtoggle ? ~wready : 1'b1;
            wr_valid   = 1'b1;
            wr_data    = {16{wseq}};
            bvalid     = (b_wait == 1);
            #1;
            if (rd_valid) begin
                rd_cnt++;
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                check("rd_data", rd_data[63:0], exp_d[63:0]);
            end
            if (data_valid) begin
                exp_q.push_back(data);
                seq++;
                rd_idx++;
                if (rw_last) rd_active = 0;
            end
            if (arvalid && arready) begin
                n_ar++; q_addr.push_back(addr); q_len.push_back(arwlen);
                rd_active = 1; rd_idx = 0; rd_len = int'(arwlen) + 1;
            end
            if (awvalid && awready) begin
                n_aw++; q_addr.push_back(addr); q_len.push_back(arwlen);
                if (b_pend) aw_overlap++;
            end
            if (bvalid) begin
                if (bready) begin bresp++; b_pend = 0; end
                b_wait = 0;
            end else if (b_wait > 1) begin
                b_wait--;
            end
            if (wvalid && wready) begin
                wbeat++; wseq++;
                if (wbeat == 1) check("wstrb_ones", wstrb[63:0], {64{1'b1}});
                if (wlast) begin wlast_at.push_back(wbeat); b_wait = 3; b_pend = 1; end
            end
            if (done) begin done_cnt++; done_cyc = cyc; fin = 1; end
            if (abort_wbeat > 0 && wbeat == abort_wbeat) begin rst = 1'b1; fin = 1; end
            @(posedge clk); #1;
            cyc++;
        end
        data_valid = 1'b0; rw_last = 1'b0; bvalid = 1'b0; wr_valid = 1'b0;
        if (!fin) check("timeout", 64'd1, 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        check_idle("reset");
        check("reset_valids", {58'd0, arvalid, awvalid, wvalid, wlast, bready, rd_valid}, 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_arwlen", 64'(arwlen), 64'd0);

        // READ 0x1000, 40 beats: three bursts 16/16/8
        run_cmd(1'b0, 32'h1000, 16'd40, 0, 0, 1'b0);
        check("r40_nar", 64'(n_ar), 64'd3);
        check("r40_naw", 64'(n_aw), 64'd0);
        if (n_ar == 3) begin
            check("r40_addr0", 64'(q_addr[0]), 64'h1000);
            check("r40_addr1", 64'(q_addr[1]), 64'h1400);
            check("r40_addr2", 64'(q_addr[2]), 64'h1800);
            check("r40_len0", 64'(q_len[0]), 64'd15);
            check("r40_len1", 64'(q_len[1]), 64'd15);
            check("r40_len2", 64'(q_len[2]), 64'd7);
        end
        check("r40_rd_cnt", 64'(rd_cnt), 64'd40);
        check("r40_done_cnt", 64'(done_cnt), 64'd1);
        check("r40_err", 64'(err), 64'd0);
        check_idle("r40_end");

        // READ across a 4 KB boundary
        run_cmd(1'b0, 32'h0FC0, 16'd8, 0, 0, 1'b0);
        check("r8_nar", 64'(n_ar), 64'd2);
        if (n_ar == 2) begin
            check("r8_addr0", 64'(q_addr[0]), 64'h0FC0);
            check("r8_len0", 64'(q_len[0]), 64'd0);
            check("r8_addr1", 64'(q_addr[1]), 64'h1000);
            check("r8_len1", 64'(q_len[1]), 64'd6);
        end
        check("r8_rd_cnt", 64'(rd_cnt), 64'd8);

        // WRITE 0x0, 20 beats, wready toggling
        run_cmd(1'b1, 32'h0, 16'd20, 0, 0, 1'b1);
        check("w20_naw", 64'(n_aw), 64'd2);
        check("w20_nar", 64'(n_ar), 64'd0);
        if (n_aw == 2) begin
            check("w20_len0", 64'(q_len[0]), 64'd15);
            check("w20_len1", 64'(q_len[1]), 64'd3);
            check("w20_addr1", 64'(q_addr[1]), 64'h400);
        end
        check("w20_nwlast", 64'(wlast_at.size()), 64'd2);
        if (wlast_at.size() == 2) begin
            check("w20_wlast0", 64'(wlast_at[0]), 64'd16);
            check("w20_wlast1", 64'(wlast_at[1]), 64'd20);
        end
        check("w20_beats", 64'(wbeat), 64'd20);
        check("w20_bresp", 64'(bresp), 64'd2);
        check("w20_aw_overlap", 64'(aw_overlap), 64'd0);
        check("w20_done_cnt", 64'(done_cnt), 64'd1);
        check_idle("w20_end");

        // Zero-beat command: done right after accept, no address phase
        run_cmd(1'b0, 32'h2000, 16'd0, 0, 0, 1'b0);
        check("z_addr_phases", 64'(n_ar + n_aw), 64'd0);
        check("z_done_cyc", 64'(done_cyc), 64'd0);
        check_idle("z_end");

        // Short read burst sets err but still completes
        run_cmd(1'b0, 32'h2000, 16'd4, 3, 0, 1'b0);
        check("s_len0", 64'(q_len.size() > 0 ? q_len[0] : 8'hFF), 64'd3);
        check("s_rd_cnt", 64'(rd_cnt), 64'd3);
        check("s_done_cnt", 64'(done_cnt), 64'd1);
        check("s_err", 64'(err), 64'd1);

        // Reset during WDATA, then a clean READ
        run_cmd(1'b1, 32'h0, 16'd20, 0, 5, 1'b1);
        check("abort_valids", {60'd0, arvalid, awvalid, wvalid, wlast}, 64'd0);
        check_idle("abort");
        check("abort_err_cleared", 64'(err), 64'd0);
        rst = 1'b0;
        run_cmd(1'b0, 32'h3000, 16'd16, 0, 0, 1'b0);
        check("post_nar", 64'(n_ar), 64'd1);
        check("post_len", 64'(q_len.size() > 0 ? q_len[0] : 8'hFF), 64'd15);
        check("post_rd_cnt", 64'(rd_cnt), 64'd16);
        check("post_done_cnt", 64'(done_cnt), 64'd1);
        check("post_err", 64'(err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
